int8_dual_acc: RTL and testbench
================================

INT8_DUAL_ACC -- requirements
Module: int8_dual_acc

Interface
REQ-001 Parameter ACC_W, default 32, signed accumulator width in bits; legal range 18..48.
REQ-002 Parameter LEN_W, default 8, width of the vector-length input.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  product pair on ac/bc is valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 ac  input  16  signed product, lane A, from the upstream int8_mult.
REQ-008 bc  input  16  signed product, lane B, from the upstream int8_mult.
REQ-009 len  input  LEN_W  number of beats in the current vector; 0 is treated as 1.
REQ-010 out_valid  output  1  result registers hold an unconsumed dot product.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 acc_a  output  ACC_W  signed dot-product result, lane A.
REQ-013 acc_b  output  ACC_W  signed dot-product result, lane B.
REQ-014 ovf  output  1  saturation occurred in either lane of the presented result.

Function
REQ-015 A beat is accepted on a rising edge where in_valid=1 and in_ready=1; a result is consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-016 The FSM has three states:
- IDLE: no beat of the current vector accepted yet.
- ACCUM: at least one beat accepted, the last beat not yet accepted.
- HOLD: a result is presented and waiting.
REQ-017 len is latched on the first accepted beat of each vector; changes to len during ACCUM or HOLD have no effect on that vector.
REQ-018 Each accepted beat sign-extends ac and bc to ACC_W and adds them to the lane-A and lane-B partial sums respectively.
REQ-019 The beat counter increments per accepted beat; the beat with counter = latched len - 1 is the last beat.
REQ-020 On the last beat:
- the final sums load acc_a/acc_b;
- ovf loads the vector's sticky flag;
- partial sums and counter clear;
- out_valid is 1 the following cycle (latency 1 cycle from last accepted beat).
REQ-021 Arithmetic saturates: a sum above 2^(ACC_W-1)-1 clamps to that value, a sum below -2^(ACC_W-1) clamps to that value, and the vector's sticky overflow flag sets.
REQ-022 The sticky overflow flag covers both lanes and clears at the start of each vector.
REQ-023 in_ready=1 in IDLE and ACCUM; in HOLD, in_ready=out_ready (combinational).
REQ-024 In HOLD, acc_a, acc_b and ovf are stable until consumed.
REQ-025 Consume without a simultaneous last beat: out_valid=0 next cycle and state -> IDLE.
REQ-026 Consume with a simultaneous accepted beat: that beat is the first beat of the next vector (len latched) and state -> ACCUM.
REQ-027 If that simultaneous beat is also last (len<=1), the new result loads and out_valid stays 1.
REQ-028 No beat is dropped or double-counted under any in_valid/out_ready pattern.
REQ-029 When len<=1, every beat is a complete vector and the block passes products through with 1-cycle latency at full throughput while out_ready=1.

Reset
REQ-030 While rst_n=0, regardless of clk:
- out_valid=0, acc_a=0, acc_b=0, ovf=0;
- partial sums, counter and overflow flag clear;
- state=IDLE;
- in_ready=0.
REQ-031 Reset asserted mid-vector or in HOLD discards partial and presented results; the first beat after rst_n rises starts a new vector.

Verification
REQ-032 len=4, beats (ac,bc)=(100,-5),(200,-5),(-50,10),(16129,-16129), out_ready=1 -> one cycle after beat 4: acc_a=16379, acc_b=-16129, ovf=0, out_valid pulse of 1 cycle.
REQ-033 ACC_W=18, len=9, all beats ac=16129, bc=-16129 -> acc_a=131071, acc_b=-131072, ovf=1; the next vector with small values shows ovf=0.
REQ-034 len=2, out_ready=0 for 5 cycles after the result, in_valid held 1 -> in_ready=0, outputs stable; on out_ready=1, the beat presented that cycle is accepted as the next vector's first beat.
REQ-035 len=1, continuous in_valid with random ac/bc, out_ready=1 -> acc_a/acc_b equal the previous cycle's ac/bc every cycle, out_valid continuously 1.
REQ-036 rst_n pulsed low after beat 2 of a len=4 vector -> outputs 0 immediately; a subsequent full len=4 vector gives correct sums with no contribution from the pre-reset beats.
REQ-037 Random in_valid/out_ready/len with the upstream int8_mult in the loop -> results match a reference model of the dot products of a*c and b*c; the bench reports failure and stops on the first mismatch.

Source files
------------

// File: rtl/int8_dual_acc.sv
// Dual-lane saturating dot-product accumulator for int8 product pairs.
// Each accepted beat adds the two 16-bit signed products into per-lane
// partial sums; after `len` beats the sums are presented with a valid/ready
// handshake and a sticky saturation flag covering both lanes.
module int8_dual_acc #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      ac,
  input  logic signed [15:0]      bc,
  input  logic [LEN_W-1:0]        len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_a,
  output logic signed [ACC_W-1:0] acc_b,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic signed [ACC_W-1:0] pa_q, pa_d;
  logic signed [ACC_W-1:0] pb_q, pb_d;
  logic                    flag_q, flag_d;
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
  logic                    ovf_q, ovf_d;

  logic                    accept;
  logic                    consume;
  logic                    first;
  logic                    last;
  logic [LEN_W-1:0]        len_eff;
  logic signed [ACC_W-1:0] base_a, base_b;
  logic signed [ACC_W-1:0] sum_a, sum_b;
  logic                    sat_a, sat_b;
  logic                    flag_new;

  // One extra bit of headroom; the top two bits disagree exactly on overflow.
  function automatic logic signed [ACC_W:0] wide_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [15:0]      b
  );
    wide_add = {a[ACC_W-1], a} + {{(ACC_W-15){b[15]}}, b};
  endfunction

  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] w);
    if (w[ACC_W] != w[ACC_W-1]) clamp = w[ACC_W] ? ACC_MIN : ACC_MAX;
    else                        clamp = w[ACC_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [ACC_W:0] w);
    clipped = (w[ACC_W] != w[ACC_W-1]);
  endfunction

  // Handshake decode; in_ready is held low throughout reset.
  always_comb begin
    in_ready = rst_n & ((state_q != S_HOLD) | out_ready);
    accept   = in_valid & in_ready;
    consume  = (state_q == S_HOLD) & out_ready;
    // A beat arriving outside ACCUM (IDLE, or HOLD while consuming) opens a new vector.
    first    = (state_q != S_ACCUM);
    len_eff  = (len == '0) ? LEN_W'(1) : len;
    last     = first ? (len_eff == LEN_W'(1)) : (cnt_q == (len_q - LEN_W'(1)));
    base_a   = first ? '0 : pa_q;
    base_b   = first ? '0 : pb_q;
    sum_a    = clamp(wide_add(base_a, ac));
    sum_b    = clamp(wide_add(base_b, bc));
    sat_a    = clipped(wide_add(base_a, ac));
    sat_b    = clipped(wide_add(base_b, bc));
    flag_new = (first ? 1'b0 : flag_q) | sat_a | sat_b;
  end

  // Next-state: accumulate, finish a vector, or retire a presented result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    flag_d  = flag_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    ovf_d   = ovf_q;
    if (accept) begin
      if (first) len_d = len_eff;
      if (last) begin
        acc_a_d = sum_a;
        acc_b_d = sum_b;
        ovf_d   = flag_new;
        pa_d    = '0;
        pb_d    = '0;
        cnt_d   = '0;
        flag_d  = 1'b0;
        state_d = S_HOLD;
      end else begin
        pa_d    = sum_a;
        pb_d    = sum_b;
        flag_d  = flag_new;
        cnt_d   = first ? LEN_W'(1) : cnt_q + LEN_W'(1);
        state_d = S_ACCUM;
      end
    end else if (consume) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      flag_q  <= 1'b0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      flag_q  <= flag_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      ovf_q   <= ovf_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid = (state_q == S_HOLD);
    acc_a     = acc_a_q;
    acc_b     = acc_b_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_int8_dual_acc.sv
// Bench for int8_dual_acc: two instances (ACC_W=32 and ACC_W=18) share the
// stimulus; a vector-level reference model predicts handshakes and results.
module tb_int8_dual_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] ac = '0;
  logic signed [15:0] bc = '0;
  logic [7:0]         len = 8'd1;

  logic               in_ready, out_valid, ovf;
  logic signed [31:0] acc_a, acc_b;
  logic               in_ready18, out_valid18, ovf18;
  logic signed [17:0] acc_a18, acc_b18;

  int n_cmp = 0;
  int n_bad = 0;

  int8_dual_acc #(.ACC_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ac(ac), .bc(bc), .len(len), .out_valid(out_valid), .out_ready(out_ready),
    .acc_a(acc_a), .acc_b(acc_b), .ovf(ovf)
  );

  int8_dual_acc #(.ACC_W(18), .LEN_W(8)) dut18 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready18),
    .ac(ac), .bc(bc), .len(len), .out_valid(out_valid18), .out_ready(out_ready),
    .acc_a(acc_a18), .acc_b(acc_b18), .ovf(ovf18)
  );

  // Reference model: index 0 models ACC_W=32, index 1 models ACC_W=18.
  logic signed [63:0] m_sa [2];
  logic signed [63:0] m_sb [2];
  logic signed [63:0] m_ra [2];
  logic signed [63:0] m_rb [2];
  bit                 m_flag [2];
  bit                 m_rovf [2];
  int                 m_cnt;
  int                 m_len;
  bit                 m_held;

  function automatic logic signed [63:0] clampw(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic bit exp_ready();
    return rst_n && (!m_held || out_ready);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sa[k] = 0; m_sb[k] = 0; m_ra[k] = 0; m_rb[k] = 0;
      m_flag[k] = 0; m_rovf[k] = 0;
    end
    m_cnt = 0; m_len = 1; m_held = 0;
  endtask

  // Advance the model by one rising edge using the inputs presented before it.
  task automatic model_step();
    bit take;
    logic signed [63:0] va, vb, sa, sb;
    int w;
    take = in_valid && exp_ready();
    if (rst_n && m_held && out_ready) m_held = 0;
    if (take) begin
      if (m_cnt == 0) begin
        m_len = (len == 0) ? 1 : int'(len);
        for (int k = 0; k < 2; k++) begin
          m_sa[k] = 0; m_sb[k] = 0; m_flag[k] = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        w  = (k == 0) ? 32 : 18;
        va = m_sa[k] + ac;
        vb = m_sb[k] + bc;
        sa = clampw(va, w);
        sb = clampw(vb, w);
        if (sa != va || sb != vb) m_flag[k] = 1;
        m_sa[k] = sa;
        m_sb[k] = sb;
      end
      m_cnt++;
      if (m_cnt == m_len) begin
        for (int k = 0; k < 2; k++) begin
          m_ra[k] = m_sa[k]; m_rb[k] = m_sb[k]; m_rovf[k] = m_flag[k];
        end
        m_held = 1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    in_valid = 0; out_ready = 0; ac = 0; bc = 0; len = 8'd1;
    model_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (acc_a !== 32'sd0 || acc_b !== 32'sd0) begin n_bad++; $display("FAIL reset_acc: got %0d/%0d want 0/0", acc_a, acc_b); end
    n_cmp++; if (ovf !== 1'b0 || ovf18 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b/%b want 0/0", ovf, ovf18); end
    n_cmp++; if (in_ready !== 1'b0 || in_ready18 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, in_ready18); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic signed [15:0] ta [4] = '{16'sd100, 16'sd200, -16'sd50, 16'sd16129};
    logic signed [15:0] tb [4] = '{-16'sd5, -16'sd5, 16'sd10, -16'sd16129};
    out_ready = 1; len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; ac = ta[i]; bc = tb[i];
      tick();
      if (i == 0) len = 8'd2; // must be ignored: len was latched on beat 1
      if (i < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir_early_valid beat%0d: got %b want 0", i, out_valid); end
      end
    end
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir_valid: got %b want 1", out_valid); end
    n_cmp++; if (acc_a !== 32'sd16379 || acc_b !== -32'sd16129) begin n_bad++; $display("FAIL dir_acc: got %0d/%0d want 16379/-16129", acc_a, acc_b); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL dir_ovf: got %b want 0", ovf); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || m_held) begin n_bad++; $display("FAIL dir_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1; len = 8'd9;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; ac = 16'sd16129; bc = -16'sd16129;
      tick();
      if (i == 0) len = 8'd3;
    end
    in_valid = 0;
    n_cmp++; if (out_valid18 !== 1'b1) begin n_bad++; $display("FAIL sat_valid18: got %b want 1", out_valid18); end
    n_cmp++; if (acc_a18 !== 18'h1FFFF || acc_b18 !== 18'h20000) begin n_bad++; $display("FAIL sat_acc18: got %0d/%0d want 131071/-131072", acc_a18, acc_b18); end
    n_cmp++; if (ovf18 !== 1'b1) begin n_bad++; $display("FAIL sat_ovf18: got %b want 1", ovf18); end
    n_cmp++; if (acc_a !== 32'sd145161 || acc_b !== -32'sd145161 || ovf !== 1'b0) begin n_bad++; $display("FAIL sat_acc32: got %0d/%0d/%b want 145161/-145161/0", acc_a, acc_b, ovf); end
    tick();
    len = 8'd2;
    in_valid = 1; ac = 16'sd3; bc = 16'sd4; tick();
    ac = 16'sd5; bc = -16'sd6; tick();
    in_valid = 0;
    n_cmp++; if (ovf18 !== 1'b0 || acc_a18 !== 18'sd8 || acc_b18 !== -18'sd2) begin n_bad++; $display("FAIL sat_next18: got %0d/%0d/%b want 8/-2/0", acc_a18, acc_b18, ovf18); end
    tick();
  endtask

  task automatic test_backpressure();
    len = 8'd2; out_ready = 0;
    in_valid = 1; ac = 16'sd7; bc = 16'sd8; tick();
    ac = 16'sd9; bc = 16'sd10; tick();
    ac = 16'sd11; bc = 16'sd12;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || acc_a !== 32'sd16 || acc_b !== 32'sd18 || ovf !== 1'b0) begin n_bad++; $display("FAIL bp_hold cyc%0d: got %b %0d/%0d want 1 16/18", i, out_valid, acc_a, acc_b); end
      tick();
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_after_consume: got %b want 0", out_valid); end
    ac = 16'sd13; bc = 16'sd14; tick();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || acc_a !== 32'sd24 || acc_b !== 32'sd26 || acc_a !== m_ra[0][31:0]) begin n_bad++; $display("FAIL bp_next_vector: got %b %0d/%0d want 1 24/26", out_valid, acc_a, acc_b); end
    tick();
  endtask

  task automatic test_passthrough();
    logic signed [15:0] pa, pb;
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      pa = 16'($urandom); pb = 16'($urandom);
      len = (i % 3 == 0) ? 8'd0 : 8'd1;
      in_valid = 1; ac = pa; bc = pb;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || acc_a !== 32'(pa) || acc_b !== 32'(pb) || ovf !== 1'b0) begin n_bad++; $display("FAIL pass cyc%0d: got %b %0d/%0d want 1 %0d/%0d", i, out_valid, acc_a, acc_b, pa, pb); end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic signed [63:0] ea, eb;
    out_ready = 1; len = 8'd4;
    in_valid = 1; ac = 16'sd1000; bc = -16'sd2000; tick();
    ac = 16'sd3000; bc = 16'sd4000; tick();
    in_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0 || acc_a !== 32'sd0 || acc_b !== 32'sd0 || ovf !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_outputs: got %b %0d/%0d %b %b want 0 0/0 0 0", out_valid, acc_a, acc_b, ovf, in_ready); end
    rst_n = 1'b1;
    tick();
    ea = 0; eb = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; ac = 16'(10 * (i + 1)); bc = 16'(-3 * (i + 1));
      ea += ac; eb += bc;
      tick();
    end
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || acc_a !== ea[31:0] || acc_b !== eb[31:0]) begin n_bad++; $display("FAIL rstmid_vector: got %b %0d/%0d want 1 %0d/%0d", out_valid, acc_a, acc_b, ea, eb); end
    tick();
  endtask

  task automatic test_random();
    byte a, b, c;
    int  start_bad;
    start_bad = n_bad;
    for (int i = 0; i < 1500 && n_bad == start_bad; i++) begin
      a = byte'($urandom); b = byte'($urandom); c = byte'($urandom);
      if ($urandom_range(0, 9) == 0) begin a = -8'sd128; b = 8'sd127; c = -8'sd128; end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      ac  = 16'(int'(a) * int'(c));
      bc  = 16'(int'(b) * int'(c));
      len = 8'($urandom_range(0, 9));
      #1;
      n_cmp++; if (in_ready !== exp_ready() || in_ready18 !== exp_ready()) begin n_bad++; $display("FAIL rnd_in_ready cyc%0d: got %b/%b want %b", i, in_ready, in_ready18, exp_ready()); end
      tick();
      n_cmp++; if (out_valid !== m_held || out_valid18 !== m_held) begin n_bad++; $display("FAIL rnd_out_valid cyc%0d: got %b/%b want %b", i, out_valid, out_valid18, m_held); end
      if (m_held) begin
        n_cmp++;
        if (acc_a !== m_ra[0][31:0] || acc_b !== m_rb[0][31:0] || ovf !== m_rovf[0] ||
            acc_a18 !== m_ra[1][17:0] || acc_b18 !== m_rb[1][17:0] || ovf18 !== m_rovf[1]) begin
          n_bad++;
          $display("FAIL rnd_result cyc%0d: got %0d/%0d/%b %0d/%0d/%b want %0d/%0d/%b %0d/%0d/%b", i,
                   acc_a, acc_b, ovf, acc_a18, acc_b18, ovf18,
                   m_ra[0], m_rb[0], m_rovf[0], m_ra[1], m_rb[1], m_rovf[1]);
        end
      end
    end
    in_valid = 0; out_ready = 1;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_saturation();
    test_backpressure();
    test_passthrough();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
